// File: rtl/branch_predictor_if.sv
// Pipeline-side bundle for the branch predictor: ID fetch/prediction, MEM resolve/recovery
// and statistics outputs. The master is the pipeline; the slave is branch_predictor.
interface branch_predictor_if;
  // Qualifier semantics: valid_ID qualifies pc_ID/ir_ID in the same cycle, resolve_MEM
  // qualifies actual_MEM/target_MEM in the same cycle; there is no backpressure, and
  // stall/flush_* from the hazard unit act at the next rising clock edge.
  logic        valid_ID;
  logic [31:0] pc_ID;
  logic [31:0] ir_ID;
  logic        stall;
  logic        flush_IDEX;
  logic        flush_EXMEM;
  logic        resolve_MEM;
  logic        actual_MEM;
  logic [31:0] target_MEM;
  logic        BP_ID;
  logic [31:0] pc_BP;
  logic        miss_MEM;
  logic [31:0] pc_fix;
  logic [31:0] stat_br;
  logic [31:0] stat_miss;

  modport master (
    output valid_ID, pc_ID, ir_ID, stall, flush_IDEX, flush_EXMEM,
           resolve_MEM, actual_MEM, target_MEM,
    input  BP_ID, pc_BP, miss_MEM, pc_fix, stat_br, stat_miss
  );

  modport slave (
    input  valid_ID, pc_ID, ir_ID, stall, flush_IDEX, flush_EXMEM,
           resolve_MEM, actual_MEM, target_MEM,
    output BP_ID, pc_BP, miss_MEM, pc_fix, stat_br, stat_miss
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal 2-bit branch predictor with EX/MEM tracking and MEM-stage misprediction recovery.
// Define BP_STATS_EN to build the stat_br/stat_miss counters; otherwise both read as 0.
module branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  branch_predictor_if.slave   bus
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]  bht [ENTRIES];

  logic        is_b;
  logic        is_jal;
  logic [31:0] b_off;
  logic [31:0] j_off;
  logic [31:0] word_off;
  logic [1:0]  id_ctr;

  logic        ex_valid, ex_isb, ex_pred;
  logic [31:0] ex_pc;
  logic        mem_valid, mem_isb, mem_pred;
  logic [31:0] mem_pc;

  logic        upd;
  logic [1:0]  upd_ctr;
  logic [1:0]  upd_next;

  assign is_b   = (bus.ir_ID[6:0] == 7'b1100011);
  assign is_jal = (bus.ir_ID[6:0] == 7'b1101111);

  // Byte offsets, then arithmetic shift to word units since PCs are word-addressed.
  assign b_off = {{20{bus.ir_ID[31]}}, bus.ir_ID[7], bus.ir_ID[30:25], bus.ir_ID[11:8], 1'b0};
  assign j_off = {{12{bus.ir_ID[31]}}, bus.ir_ID[19:12], bus.ir_ID[20], bus.ir_ID[30:21], 1'b0};

  always_comb begin
    word_off = 32'd1;
    if (is_b)        word_off = {{2{b_off[31]}}, b_off[31:2]};
    else if (is_jal) word_off = {{2{j_off[31]}}, j_off[31:2]};
  end

  assign id_ctr     = bht[bus.pc_ID[IDX_W-1:0]];
  assign bus.pc_BP  = bus.pc_ID + word_off;
  assign bus.BP_ID  = bus.valid_ID & ~bus.stall & (is_jal | (is_b & id_ctr[1]));

  assign bus.miss_MEM = mem_valid & bus.resolve_MEM & (bus.actual_MEM != mem_pred);
  assign bus.pc_fix   = bus.actual_MEM ? bus.target_MEM : (mem_pc + 32'd1);

  assign upd     = mem_valid & mem_isb & bus.resolve_MEM;
  assign upd_ctr = bht[mem_pc[IDX_W-1:0]];

  always_comb begin
    upd_next = upd_ctr;
    if (bus.actual_MEM) begin
      if (upd_ctr != 2'b11) upd_next = upd_ctr + 2'b01;
    end else begin
      if (upd_ctr != 2'b00) upd_next = upd_ctr - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid  <= 1'b0;
      ex_isb    <= 1'b0;
      ex_pred   <= 1'b0;
      ex_pc     <= '0;
      mem_valid <= 1'b0;
      mem_isb   <= 1'b0;
      mem_pred  <= 1'b0;
      mem_pc    <= '0;
    end else begin
      ex_valid  <= bus.valid_ID & ~bus.stall & ~bus.flush_IDEX;
      ex_isb    <= is_b;
      ex_pred   <= bus.BP_ID;
      ex_pc     <= bus.pc_ID;
      mem_valid <= ex_valid & ~bus.flush_EXMEM;
      mem_isb   <= ex_isb;
      mem_pred  <= ex_pred;
      mem_pc    <= ex_pc;
    end
  end

  // The ID read is combinational off the array, so a same-cycle update is not bypassed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht[i] <= 2'b01;
    end else if (upd) begin
      bht[mem_pc[IDX_W-1:0]] <= upd_next;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q   <= '0;
      stat_miss_q <= '0;
    end else begin
      if (upd)          stat_br_q   <= stat_br_q + 32'd1;
      if (bus.miss_MEM) stat_miss_q <= stat_miss_q + 32'd1;
    end
  end

  assign bus.stat_br   = stat_br_q;
  assign bus.stat_miss = stat_miss_q;
`else
  assign bus.stat_br   = '0;
  assign bus.stat_miss = '0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a decode/target vector table plus hand-written
// multi-cycle sequences for training, saturation, JAL, stall/flush, bypass and reset.
module tb_branch_predictor;
  logic clk;
  logic rst_n;

  branch_predictor_if bus ();

  branch_predictor #(.IDX_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] IR_B16  = 32'h0000_0863; // beq x0,x0,+16
  localparam logic [31:0] IR_BM4  = 32'hFE00_0EE3; // beq x0,x0,-4
  localparam logic [31:0] IR_JM8  = 32'hFF9F_F06F; // jal x0,-8
  localparam logic [31:0] IR_ADDI = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] IR_JALR = 32'h0000_8067; // jalr x0,0(x1)

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic        valid;
    logic        stall;
    logic        exp_bp;
    logic [31:0] exp_pc_bp;
  } vec_t;

  vec_t vecs [8];

  int n_vec  = 0;
  int n_miss = 0;
  int exp_br_cnt   = 0;
  int exp_miss_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input int c);
`ifdef BP_STATS_EN
    return 32'(c);
`else
    return 32'd0 + 32'(c * 0);
`endif
  endfunction

  task automatic check_stats(input string name);
    check({name, ".stat_br"},   bus.stat_br,   stat_exp(exp_br_cnt));
    check({name, ".stat_miss"}, bus.stat_miss, stat_exp(exp_miss_cnt));
  endtask

  task automatic idle_inputs();
    bus.valid_ID    = 1'b0;
    bus.pc_ID       = '0;
    bus.ir_ID       = '0;
    bus.stall       = 1'b0;
    bus.flush_IDEX  = 1'b0;
    bus.flush_EXMEM = 1'b0;
    bus.resolve_MEM = 1'b0;
    bus.actual_MEM  = 1'b0;
    bus.target_MEM  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID, let it reach MEM, then resolve it there.
  task automatic issue_resolve(input string name, input logic [31:0] pc, input logic [31:0] ir,
                               input logic is_b, input logic exp_bp, input logic actual,
                               input logic [31:0] target, input logic exp_miss,
                               input logic [31:0] exp_fix);
    bus.valid_ID = 1'b1;
    bus.pc_ID    = pc;
    bus.ir_ID    = ir;
    #1;
    check({name, ".BP_ID"}, 32'(bus.BP_ID), 32'(exp_bp));
    next_cycle();
    bus.valid_ID = 1'b0;
    next_cycle();
    bus.resolve_MEM = 1'b1;
    bus.actual_MEM  = actual;
    bus.target_MEM  = target;
    #1;
    check({name, ".miss_MEM"}, 32'(bus.miss_MEM), 32'(exp_miss));
    check({name, ".pc_fix"},   bus.pc_fix,        exp_fix);
    next_cycle();
    bus.resolve_MEM = 1'b0;
    bus.actual_MEM  = 1'b0;
    if (is_b)     exp_br_cnt++;
    if (exp_miss) exp_miss_cnt++;
    check_stats(name);
  endtask

  task automatic probe_id(input string name, input logic [31:0] pc, input logic [31:0] ir,
                          input logic exp_bp);
    bus.valid_ID = 1'b1;
    bus.pc_ID    = pc;
    bus.ir_ID    = ir;
    #1;
    check({name, ".BP_ID"}, 32'(bus.BP_ID), 32'(exp_bp));
    bus.valid_ID = 1'b0;
  endtask

  initial begin
    vecs[0] = '{32'h10, IR_B16,  1'b1, 1'b0, 1'b0, 32'h14};
    vecs[1] = '{32'h20, IR_JM8,  1'b1, 1'b0, 1'b1, 32'h1E};
    vecs[2] = '{32'h30, IR_ADDI, 1'b1, 1'b0, 1'b0, 32'h31};
    vecs[3] = '{32'h20, IR_JM8,  1'b1, 1'b1, 1'b0, 32'h1E};
    vecs[4] = '{32'h20, IR_JM8,  1'b0, 1'b0, 1'b0, 32'h1E};
    vecs[5] = '{32'h40, IR_BM4,  1'b1, 1'b0, 1'b0, 32'h3F};
    vecs[6] = '{32'h50, IR_JALR, 1'b1, 1'b0, 1'b0, 32'h51};
    vecs[7] = '{32'h3F, IR_ADDI, 1'b1, 1'b0, 1'b0, 32'h40};

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.miss_MEM", 32'(bus.miss_MEM), 32'd0);
    check_stats("reset");
    rst_n = 1'b1;
    next_cycle();
    bus.resolve_MEM = 1'b1;
    bus.actual_MEM  = 1'b1;
    #1;
    check("post_reset.miss_MEM", 32'(bus.miss_MEM), 32'd0);
    bus.resolve_MEM = 1'b0;
    bus.actual_MEM  = 1'b0;
    next_cycle();

    for (int i = 0; i < 8; i++) begin
      bus.pc_ID    = vecs[i].pc;
      bus.ir_ID    = vecs[i].ir;
      bus.valid_ID = vecs[i].valid;
      bus.stall    = vecs[i].stall;
      #1;
      check($sformatf("vec%0d.BP_ID", i), 32'(bus.BP_ID), 32'(vecs[i].exp_bp));
      check($sformatf("vec%0d.pc_BP", i), bus.pc_BP, vecs[i].exp_pc_bp);
      next_cycle();
    end
    idle_inputs();
    repeat (2) next_cycle();

    // Training 01->10->11, then not-taken and saturation at 11.
    issue_resolve("train1", 32'h10, IR_B16, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h14);
    issue_resolve("train2", 32'h10, IR_B16, 1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h14);
    probe_id("strong", 32'h10, IR_B16, 1'b1);
    check("strong.pc_BP", bus.pc_BP, 32'h14);
    issue_resolve("nt1",    32'h10, IR_B16, 1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 32'h11);
    for (int k = 0; k < 4; k++)
      issue_resolve($sformatf("sat%0d", k), 32'h10, IR_B16, 1'b1, 1'b1, 1'b1, 32'h14, 1'b0, 32'h14);
    issue_resolve("nt2",    32'h10, IR_B16, 1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 32'h11);
    issue_resolve("nt3",    32'h10, IR_B16, 1'b1, 1'b1, 1'b0, 32'h14, 1'b1, 32'h11);
    issue_resolve("retake", 32'h10, IR_B16, 1'b1, 1'b0, 1'b1, 32'h14, 1'b1, 32'h14);

    // JAL must not touch the BHT entry at its PC.
    issue_resolve("jal", 32'h20, IR_JM8, 1'b0, 1'b1, 1'b1, 32'h1E, 1'b0, 32'h1E);
    probe_id("jal_nobht", 32'h20, IR_B16, 1'b0);
    check("jal_nobht.pc_BP", bus.pc_BP, 32'h24);

    // Stall: no redirect, and the instruction becomes an EX bubble.
    bus.valid_ID = 1'b1; bus.pc_ID = 32'h10; bus.ir_ID = IR_B16; bus.stall = 1'b1;
    #1;
    check("stall.BP_ID", 32'(bus.BP_ID), 32'd0);
    next_cycle();
    bus.valid_ID = 1'b0; bus.stall = 1'b0;
    next_cycle();
    bus.resolve_MEM = 1'b1; bus.actual_MEM = 1'b0;
    #1;
    check("stall.miss_MEM", 32'(bus.miss_MEM), 32'd0);
    next_cycle();
    bus.resolve_MEM = 1'b0;
    probe_id("stall_noupd", 32'h10, IR_B16, 1'b1);
    check_stats("stall");

    // flush_EXMEM while the branch sits in EX.
    bus.valid_ID = 1'b1; bus.pc_ID = 32'h10; bus.ir_ID = IR_B16;
    #1;
    check("flush.BP_ID", 32'(bus.BP_ID), 32'd1);
    next_cycle();
    bus.valid_ID = 1'b0; bus.flush_EXMEM = 1'b1;
    next_cycle();
    bus.flush_EXMEM = 1'b0; bus.resolve_MEM = 1'b1; bus.actual_MEM = 1'b0;
    #1;
    check("flush.miss_MEM", 32'(bus.miss_MEM), 32'd0);
    next_cycle();
    bus.resolve_MEM = 1'b0;
    probe_id("flush_noupd", 32'h10, IR_B16, 1'b1);
    check_stats("flush");

    // Same-cycle read and update of one index returns the pre-update counter.
    bus.valid_ID = 1'b1; bus.pc_ID = 32'h10; bus.ir_ID = IR_B16;
    next_cycle();
    bus.valid_ID = 1'b0;
    next_cycle();
    bus.valid_ID = 1'b1; bus.resolve_MEM = 1'b1; bus.actual_MEM = 1'b0;
    #1;
    check("bypass.BP_ID",    32'(bus.BP_ID),    32'd1);
    check("bypass.miss_MEM", 32'(bus.miss_MEM), 32'd1);
    check("bypass.pc_fix",   bus.pc_fix,        32'h11);
    next_cycle();
    bus.resolve_MEM = 1'b0;
    exp_br_cnt++; exp_miss_cnt++;
    check("bypass_after.BP_ID", 32'(bus.BP_ID), 32'd0);
    check_stats("bypass");
    bus.valid_ID = 1'b0;
    repeat (3) next_cycle();

    // Reset mid-flight: in-flight branch discarded, stats cleared.
    bus.valid_ID = 1'b1; bus.pc_ID = 32'h10; bus.ir_ID = IR_B16;
    next_cycle();
    bus.valid_ID = 1'b0;
    next_cycle();
    bus.resolve_MEM = 1'b1; bus.actual_MEM = 1'b1; bus.target_MEM = 32'h14;
    #1;
    check("midrst_pre.miss_MEM", 32'(bus.miss_MEM), 32'd1);
    rst_n = 1'b0;
    #1;
    exp_br_cnt = 0; exp_miss_cnt = 0;
    check("midrst.miss_MEM", 32'(bus.miss_MEM), 32'd0);
    check_stats("midrst");
    next_cycle();
    rst_n = 1'b1;
    bus.resolve_MEM = 1'b0; bus.actual_MEM = 1'b0;
    next_cycle();
    probe_id("midrst_bht", 32'h10, IR_B16, 1'b0);
    check_stats("midrst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
